// File: rtl/bsg_arb_round_robin_lock.sv
// Round-robin arbiter with rotating priority and optional grant lock for multi-beat transfers.
// Define BSG_ARB_RR_LOCK_EN to add the lock_i port and the IDLE/LOCKED hold state machine.
module bsg_arb_round_robin_lock #(
  parameter int width_p = 4,
  localparam int lg_width = (width_p > 1) ? $clog2(width_p) : 1
) (
  input  logic                clk_i,
  input  logic                reset_n_i,
  input  logic [width_p-1:0]  reqs_i,
  input  logic                yumi_i,
`ifdef BSG_ARB_RR_LOCK_EN
  input  logic                lock_i,
`endif
  output logic [width_p-1:0]  grants_one_hot_o,
  output logic [lg_width-1:0] tag_o,
  output logic                v_o
);

  logic [lg_width-1:0] last_r, last_n;
  logic [lg_width-1:0] scan_tag, win_tag;
  logic                scan_v, win_v, scan_found;

  assign scan_v = |reqs_i;

  // Search starts just above the last accepted index and wraps modulo width_p.
  always_comb begin
    scan_found = 1'b0;
    scan_tag   = '0;
    for (int i = 1; i <= width_p; i++) begin
      for (int k = 0; k < width_p; k++) begin
        if (!scan_found && reqs_i[k] && (k == ((int'(last_r) + i) % width_p))) begin
          scan_found = 1'b1;
          scan_tag   = lg_width'(k);
        end
      end
    end
  end

`ifdef BSG_ARB_RR_LOCK_EN
  typedef enum logic {IDLE, LOCKED} state_e;

  state_e              fsm_r, fsm_n;
  logic [lg_width-1:0] locked_tag_r, locked_tag_n;
  logic                locked_req, commit;

  always_comb begin
    locked_req = 1'b0;
    for (int k = 0; k < width_p; k++) begin
      if (locked_tag_r == lg_width'(k)) locked_req = reqs_i[k];
    end
  end

  always_comb begin
    fsm_n        = fsm_r;
    locked_tag_n = locked_tag_r;
    last_n       = last_r;
    win_v        = scan_v;
    win_tag      = scan_tag;
    if (fsm_r == LOCKED) begin
      win_v   = locked_req;
      win_tag = locked_tag_r;
    end
    commit = win_v & yumi_i & reset_n_i;
    case (fsm_r)
      IDLE: begin
        if (commit) begin
          last_n = scan_tag;
          if (lock_i) begin
            fsm_n        = LOCKED;
            locked_tag_n = scan_tag;
          end
        end
      end
      LOCKED: begin
        if (commit && !lock_i) begin
          fsm_n  = IDLE;
          last_n = locked_tag_r;
        end
      end
      default: fsm_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      last_r       <= lg_width'(width_p - 1);
      fsm_r        <= IDLE;
      locked_tag_r <= '0;
    end else begin
      last_r       <= last_n;
      fsm_r        <= fsm_n;
      locked_tag_r <= locked_tag_n;
    end
  end
`else
  always_comb begin
    win_v   = scan_v;
    win_tag = scan_tag;
    last_n  = last_r;
    if (win_v && yumi_i) last_n = scan_tag;
  end

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) last_r <= lg_width'(width_p - 1);
    else            last_r <= last_n;
  end
`endif

  // Outputs are forced quiet while reset is held, independent of state.
  always_comb begin
    v_o              = 1'b0;
    tag_o            = '0;
    grants_one_hot_o = '0;
    if (reset_n_i && win_v) begin
      v_o   = 1'b1;
      tag_o = win_tag;
      for (int k = 0; k < width_p; k++) begin
        grants_one_hot_o[k] = (win_tag == lg_width'(k));
      end
    end
  end

endmodule

// File: tb/tb_bsg_arb_round_robin_lock.sv
// Scoreboard bench for bsg_arb_round_robin_lock (width_p=4); lock scenarios need BSG_ARB_RR_LOCK_EN.
module tb_bsg_arb_round_robin_lock;

  logic       clk_i = 1'b0;
  logic       reset_n_i = 1'b0;
  logic [3:0] reqs_i = '0;
  logic       yumi_i = 1'b0;
  logic       lock_i = 1'b0;
  logic [3:0] grants_one_hot_o;
  logic [1:0] tag_o;
  logic       v_o;

  typedef struct {
    string      name;
    logic       v;
    logic [3:0] grant;
    logic [1:0] tag;
  } exp_t;

  exp_t expQ[$];
  int   asserts = 0;
  int   failures = 0;
  int   protocolErrs = 0;

  bsg_arb_round_robin_lock #(.width_p(4)) dut (
    .clk_i            (clk_i),
    .reset_n_i        (reset_n_i),
    .reqs_i           (reqs_i),
    .yumi_i           (yumi_i),
`ifdef BSG_ARB_RR_LOCK_EN
    .lock_i           (lock_i),
`endif
    .grants_one_hot_o (grants_one_hot_o),
    .tag_o            (tag_o),
    .v_o              (v_o)
  );

  always #5 clk_i = ~clk_i;

  // yumi while nothing is offered is a protocol violation; test 4 provokes exactly one.
  always @(posedge clk_i) begin
    if (reset_n_i && yumi_i && !v_o) begin
      protocolErrs++;
      $display("[TB] protocol violation: yumi_i with v_o=0 at %0t", $time);
    end
  end

  task automatic checkOutput(input string name, input logic [3:0] act, input logic [3:0] exp);
    asserts++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input string name, input logic rstn, input logic [3:0] reqs,
                               input logic yumi, input logic lock, input logic expV,
                               input logic [3:0] expGrant, input logic [1:0] expTag);
    exp_t e;
    @(posedge clk_i);
    #1;
    reset_n_i = rstn;
    reqs_i    = reqs;
    yumi_i    = yumi;
    lock_i    = lock;
    e.name  = name;
    e.v     = expV;
    e.grant = expGrant;
    e.tag   = expTag;
    expQ.push_back(e);
  endtask

  // Monitor: compare presented outputs mid-cycle against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput({e.name, ".v"},     {3'b0, v_o},   {3'b0, e.v});
        checkOutput({e.name, ".grant"}, grants_one_hot_o, e.grant);
        checkOutput({e.name, ".tag"},   {2'b0, tag_o}, {2'b0, e.tag});
      end
    end
  end

  initial begin
    int drain;
    // Reset: outputs forced to zero even with requests and yumi asserted.
    applyStimulus("rst0", 0, 4'b1111, 1, 0, 0, 4'b0000, 2'd0);
    applyStimulus("rst1", 0, 4'b1111, 1, 0, 0, 4'b0000, 2'd0);

    // Test 1: all requesting, full rotation with wrap.
    applyStimulus("t1a", 1, 4'b1111, 1, 0, 1, 4'b0001, 2'd0);
    applyStimulus("t1b", 1, 4'b1111, 1, 0, 1, 4'b0010, 2'd1);
    applyStimulus("t1c", 1, 4'b1111, 1, 0, 1, 4'b0100, 2'd2);
    applyStimulus("t1d", 1, 4'b1111, 1, 0, 1, 4'b1000, 2'd3);
    applyStimulus("t1e", 1, 4'b1111, 1, 0, 1, 4'b0001, 2'd0);

    // Test 2: sparse requests alternate.
    applyStimulus("t2rst", 0, 4'b1010, 1, 0, 0, 4'b0000, 2'd0);
    applyStimulus("t2a", 1, 4'b1010, 1, 0, 1, 4'b0010, 2'd1);
    applyStimulus("t2b", 1, 4'b1010, 1, 0, 1, 4'b1000, 2'd3);
    applyStimulus("t2c", 1, 4'b1010, 1, 0, 1, 4'b0010, 2'd1);
    applyStimulus("t2d", 1, 4'b1010, 1, 0, 1, 4'b1000, 2'd3);

    // Test 3: grant holds without yumi, advances after one accept.
    applyStimulus("t3rst", 0, 4'b0110, 0, 0, 0, 4'b0000, 2'd0);
    applyStimulus("t3a", 1, 4'b0110, 0, 0, 1, 4'b0010, 2'd1);
    applyStimulus("t3b", 1, 4'b0110, 0, 0, 1, 4'b0010, 2'd1);
    applyStimulus("t3c", 1, 4'b0110, 0, 0, 1, 4'b0010, 2'd1);
    applyStimulus("t3acc", 1, 4'b0110, 1, 0, 1, 4'b0010, 2'd1);
    applyStimulus("t3next", 1, 4'b0110, 0, 0, 1, 4'b0100, 2'd2);

    // Test 4: yumi with no requests is ignored; pointer unchanged (last=1).
    applyStimulus("t4idle", 1, 4'b0000, 1, 0, 0, 4'b0000, 2'd0);
    applyStimulus("t4same", 1, 4'b1111, 0, 0, 1, 4'b0100, 2'd2);
    applyStimulus("t4drop", 1, 4'b1011, 0, 0, 1, 4'b1000, 2'd3);

`ifdef BSG_ARB_RR_LOCK_EN
    // Test 5: lock on requester 2 across three beats, then release.
    applyStimulus("t5rst", 0, 4'b0000, 0, 0, 0, 4'b0000, 2'd0);
    applyStimulus("t5lock", 1, 4'b0100, 1, 1, 1, 4'b0100, 2'd2);
    applyStimulus("t5b1", 1, 4'b1111, 1, 1, 1, 4'b0100, 2'd2);
    applyStimulus("t5b2", 1, 4'b1111, 1, 1, 1, 4'b0100, 2'd2);
    applyStimulus("t5b3", 1, 4'b1111, 1, 1, 1, 4'b0100, 2'd2);
    applyStimulus("t5rel", 1, 4'b1111, 1, 0, 1, 4'b0100, 2'd2);
    applyStimulus("t5next", 1, 4'b1111, 0, 0, 1, 4'b1000, 2'd3);
    // Locked requester drops its request: nothing offered, lock persists.
    applyStimulus("t5lk3", 1, 4'b1111, 1, 1, 1, 4'b1000, 2'd3);
    applyStimulus("t5drop", 1, 4'b0111, 0, 0, 0, 4'b0000, 2'd0);
    applyStimulus("t5back", 1, 4'b1111, 0, 0, 1, 4'b1000, 2'd3);

    // Test 6: reset while locked on requester 2 returns to IDLE.
    applyStimulus("t6rst", 0, 4'b0000, 0, 0, 0, 4'b0000, 2'd0);
    applyStimulus("t6lock", 1, 4'b0100, 1, 1, 1, 4'b0100, 2'd2);
    applyStimulus("t6held", 1, 4'b1111, 0, 0, 1, 4'b0100, 2'd2);
    applyStimulus("t6pull", 0, 4'b1111, 1, 0, 0, 4'b0000, 2'd0);
    applyStimulus("t6idle", 1, 4'b1111, 0, 0, 1, 4'b0001, 2'd0);
`endif

    @(posedge clk_i);
    #1;
    yumi_i = 1'b0;
    drain = 0;
    while (expQ.size() > 0 && drain < 20) begin
      @(posedge clk_i);
      drain++;
    end
    if (expQ.size() > 0) begin
      asserts++;
      failures++;
      $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
    end
    checkOutput("protocolErrs", 4'(protocolErrs), 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
    $finish;
  end

endmodule
